handshake_rr_arbiter: RTL

Round-robin arbiter that shares one ready/valid datapath between three ready/valid requesters. Requester channels are `handshake_arr_0..2`; the shared downstream channel is `handshake`. It uses a burst-lock counter so a winner can keep the grant for up to `BURST` consecutive beats. A one-entry registered output stage decouples the arbitration logic from downstream backpressure while still sustaining one beat per cycle.

---
 rtl/handshake_rr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/handshake_rr_arbiter.sv
// rtl/handshake_rr_arbiter.sv - three-way round-robin ready/valid arbiter with burst lock
// and a one-entry registered output stage.
module handshake_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int BURST = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             handshake_arr_0_valid,
  output logic             handshake_arr_0_ready,
  input  logic [WIDTH-1:0] arr_data_0,
  input  logic             handshake_arr_1_valid,
  output logic             handshake_arr_1_ready,
  input  logic [WIDTH-1:0] arr_data_1,
  input  logic             handshake_arr_2_valid,
  output logic             handshake_arr_2_ready,
  input  logic [WIDTH-1:0] arr_data_2,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_grant
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [2:0]       valid;
  logic             load, lock, sel_ok, accept;
  logic [1:0]       sel, p1, p2;
  logic [WIDTH-1:0] sel_data;
  logic [2:0]       ready_vec;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign valid = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid};

  always_comb begin
    load   = !ov_q || handshake_ready;
    lock   = (cnt_q != 4'd0) && (cnt_q < BURST_C) && valid[last_q];
    p1     = inc3(ptr_q);
    p2     = inc3(p1);
    sel    = ptr_q;
    sel_ok = 1'b0;
    if (lock) begin
      sel    = last_q;
      sel_ok = 1'b1;
    end else if (valid[ptr_q]) begin
      sel    = ptr_q;
      sel_ok = 1'b1;
    end else if (valid[p1]) begin
      sel    = p1;
      sel_ok = 1'b1;
    end else if (valid[p2]) begin
      sel    = p2;
      sel_ok = 1'b1;
    end
    accept = sel_ok && load;
  end

  always_comb begin
    case (sel)
      2'd0:    sel_data = arr_data_0;
      2'd1:    sel_data = arr_data_1;
      default: sel_data = arr_data_2;
    endcase
  end

  // Readies are masked by reset so no requester sees a handshake while the stage is cleared.
  always_comb begin
    ready_vec = 3'b000;
    if (accept && !ASYNCRESET) begin
      ready_vec = 3'b001 << sel;
    end
  end

  assign handshake_arr_0_ready = ready_vec[0];
  assign handshake_arr_1_ready = ready_vec[1];
  assign handshake_arr_2_ready = ready_vec[2];

  always_comb begin
    ov_d    = ov_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (accept) begin
      ov_d    = 1'b1;
      data_d  = sel_data;
      grant_d = sel;
      last_d  = sel;
      ptr_d   = inc3(sel);
      if (sel == last_q) begin
        cnt_d = (cnt_q >= BURST_C) ? BURST_C : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end else if (handshake_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      ov_q    <= 1'b0;
      data_q  <= '0;
      grant_q <= 2'd0;
      ptr_q   <= 2'd0;
      last_q  <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      ov_q    <= ov_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign handshake_valid = ov_q;
  assign out_data        = data_q;
  assign out_grant       = grant_q;

endmodule
